// File: rtl/chs_pkg.sv
// chs_pkg: shared state/mode encodings, default thresholds and helpers for the temperature speed controller
package chs_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, COOL = 2'd1, HEAT = 2'd2, DRAIN = 2'd3} state_t;
   typedef enum logic [1:0] {MODE_OFF = 2'b00, MODE_COOL = 2'b01, MODE_HEAT = 2'b10} mode_t;
   localparam logic [7:0] T_COOL_ON_DEF  = 8'd30;
   localparam logic [7:0] T_COOL_OFF_DEF = 8'd27;
   localparam logic [7:0] T_HEAT_ON_DEF  = 8'd15;
   localparam logic [7:0] T_HEAT_OFF_DEF = 8'd18;
   localparam int         GAIN_SH_DEF    = 4;
   localparam int         RAMP_DIV_DEF   = 16;
   localparam logic [7:0] RAMP_STEP_DEF  = 8'd8;
   function automatic logic [7:0] sat8(input logic [31:0] v);
      return (v > 32'd255) ? 8'hff : v[7:0];
   endfunction
endpackage

// File: rtl/speed_ramp.sv
// speed_ramp: moves the fan speed toward a target by a bounded step once every RAMP_DIV cycles
module speed_ramp import chs_pkg::*; #(
   parameter int         RAMP_DIV  = RAMP_DIV_DEF,
   parameter logic [7:0] RAMP_STEP = RAMP_STEP_DEF
) (
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] target,
   output logic [7:0] speed
);
   localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);
   if (RAMP_DIV < 1) begin : g_bad_div
      $error("speed_ramp: RAMP_DIV must be at least 1");
   end
   logic [CW-1:0] cnt;
   logic          tick;
   logic          up;
   logic [7:0]    diff;
   logic [7:0]    step;
   // Tick detection and the clamped step, so speed lands exactly on the target
   always_comb begin
      tick = cnt == LAST;
      up = target > speed;
      diff = up ? target - speed : speed - target;
      step = diff < RAMP_STEP ? diff : RAMP_STEP;
   end
   // Free-running tick counter; speed only moves on a tick
   always_ff @(posedge clk)
      if (arst) begin
         cnt <= '0;
         speed <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         if (tick) speed <= up ? speed + step : speed - step;
      end
endmodule

// File: rtl/temp_speed_ctrl.sv
// temp_speed_ctrl: hysteresis cool/heat controller that derives a fan speed target from the temperature error
module temp_speed_ctrl import chs_pkg::*; #(
   parameter logic [7:0] T_COOL_ON  = T_COOL_ON_DEF,
   parameter logic [7:0] T_COOL_OFF = T_COOL_OFF_DEF,
   parameter logic [7:0] T_HEAT_ON  = T_HEAT_ON_DEF,
   parameter logic [7:0] T_HEAT_OFF = T_HEAT_OFF_DEF,
   parameter int         GAIN_SH    = GAIN_SH_DEF,
   parameter int         RAMP_DIV   = RAMP_DIV_DEF,
   parameter logic [7:0] RAMP_STEP  = RAMP_STEP_DEF
) (
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] temp_data,
   input  logic       temp_valid,
   output logic [7:0] speed,
   output logic [1:0] chs_mode,
   output logic       chs_power
);
   if (!(T_HEAT_ON < T_HEAT_OFF && T_HEAT_OFF < T_COOL_OFF && T_COOL_OFF < T_COOL_ON)) begin : g_bad_thresholds
      $error("temp_speed_ctrl: thresholds must satisfy T_HEAT_ON < T_HEAT_OFF < T_COOL_OFF < T_COOL_ON");
   end
   if (GAIN_SH < 0 || GAIN_SH > 24) begin : g_bad_gain
      $error("temp_speed_ctrl: GAIN_SH must be within 0..24 so the shifted error fits 32 bits");
   end
   state_t      state;
   state_t      next_state;
   mode_t       mode;
   mode_t       next_mode;
   logic [7:0]  temp_reg;
   logic [7:0]  target;
   logic [31:0] err;
   assign chs_mode = mode;
   // Capture the temperature whenever the sensor qualifies it
   always_ff @(posedge clk)
      if (arst) temp_reg <= '0;
      else if (temp_valid) temp_reg <= temp_data;
   // State register; mode and power are registered with it so all three change on the same edge
   always_ff @(posedge clk)
      if (arst) begin
         state <= IDLE;
         mode <= MODE_OFF;
         chs_power <= 1'b0;
      end else begin
         state <= next_state;
         mode <= next_mode;
         chs_power <= next_state != IDLE;
      end
   // Next state: COOL and HEAT only leave through DRAIN, which waits for the fan to stop
   always_comb
      case (state)
         IDLE:    next_state = temp_reg >= T_COOL_ON ? COOL : temp_reg <= T_HEAT_ON ? HEAT : IDLE;
         COOL:    next_state = temp_reg < T_COOL_OFF ? DRAIN : COOL;
         HEAT:    next_state = temp_reg > T_HEAT_OFF ? DRAIN : HEAT;
         default: next_state = speed == 8'd0 ? IDLE : DRAIN;
      endcase
   // Outputs: DRAIN keeps the last mode; target is the wide error, clipped at zero and 255
   always_comb begin
      next_mode = next_state == COOL ? MODE_COOL : next_state == HEAT ? MODE_HEAT : next_state == DRAIN ? mode : MODE_OFF;
      err = state == COOL && temp_reg >= T_COOL_OFF ? 32'(temp_reg - T_COOL_OFF)
          : state == HEAT && temp_reg <= T_HEAT_OFF ? 32'(T_HEAT_OFF - temp_reg) : 32'd0;
      target = sat8(err << GAIN_SH);
   end
   speed_ramp #(.RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)) u_ramp (
      .clk   (clk),
      .arst  (arst),
      .target(target),
      .speed (speed)
   );
endmodule

// File: doc/temp_speed_ctrl.md
TEMP_SPEED_CTRL -- requirements
Module: temp_speed_ctrl

Interface
REQ-001 SHALL have parameter T_COOL_ON, default 8'd30, meaning temperature at or above which cooling starts.
REQ-002 SHALL have parameter T_COOL_OFF, default 8'd27, meaning temperature below which cooling stops.
REQ-003 SHALL have parameter T_HEAT_ON, default 8'd15, meaning temperature at or below which heating starts.
REQ-004 SHALL have parameter T_HEAT_OFF, default 8'd18, meaning temperature above which heating stops.
REQ-005 SHALL have parameter GAIN_SH, default 4, meaning left-shift applied to the temperature error to form the target speed.
REQ-006 SHALL have parameter RAMP_DIV, default 16, meaning clock cycles per ramp tick, minimum 1.
REQ-007 SHALL have parameter RAMP_STEP, default 8'd8, meaning maximum speed change per ramp tick.
REQ-008 SHALL have port clk  input  1  clock, posedge.
REQ-009 SHALL have port arst  input  1  reset, synchronous, active-high; one clock; no other clock domains.
REQ-010 SHALL have port temp_data  input  8  unsigned temperature sample in degrees C.
REQ-011 SHALL have port temp_valid  input  1  qualifies temp_data for one cycle.
REQ-012 SHALL have port speed  output  8  fan duty-cycle command to the downstream PWM fan stage.
REQ-013 SHALL have port chs_mode  output  2  encoded as 00 off, 01 cool, 10 heat; 11 never driven.
REQ-014 SHALL have port chs_power  output  1  system power enable.

Function
REQ-015 SHALL latch temp_data into temp_reg on each cycle in which temp_valid=1; otherwise temp_reg holds its value.
REQ-016 SHALL implement FSM states IDLE, COOL, HEAT, DRAIN, with all decisions made on temp_reg.
REQ-017 IDLE: SHALL go to COOL if temp_reg >= T_COOL_ON, else to HEAT if temp_reg <= T_HEAT_ON, else stay; mode 00, power 0, target 0.
REQ-018 COOL: SHALL go to DRAIN if temp_reg < T_COOL_OFF; mode 01, power 1, target = min(255, (temp_reg - T_COOL_OFF) << GAIN_SH).
REQ-019 HEAT: SHALL go to DRAIN if temp_reg > T_HEAT_OFF; mode 10, power 1, target = min(255, (T_HEAT_OFF - temp_reg) << GAIN_SH).
REQ-020 DRAIN: SHALL keep the previous mode and power 1, target 0, and go to IDLE in the cycle after speed == 0; temperature changes are ignored until then.
REQ-021 SHALL compute the target at full width (at least 16 bits) before saturating to 255; a negative error SHALL yield target 0.
REQ-022 SHALL run a free-running tick counter 0..RAMP_DIV-1; a tick occurs when the count equals RAMP_DIV-1.
REQ-023 On a tick, speed SHALL move toward the target by min(RAMP_STEP, |target - speed|), never overshooting; between ticks, speed holds.
REQ-024 Latency: temp_valid at edge n updates temp_reg at n+1, and state, mode and power at n+2.
REQ-025 A direct COOL<->HEAT transition SHALL be impossible; every exit passes through DRAIN and IDLE.
REQ-026 Parameter legality: T_HEAT_ON < T_HEAT_OFF < T_COOL_OFF < T_COOL_ON; a violation SHALL be flagged by an elaboration-time check.

Reset
REQ-027 While arst=1 at a clk edge, the block SHALL set state=IDLE, temp_reg=0, speed=0, chs_mode=00, chs_power=0, and tick counter=0.
REQ-028 Reset mid-ramp or mid-DRAIN SHALL take effect at the next edge, with no ramp-down.

Structure
REQ-029 State encoding, chs_mode codes, and the default thresholds SHALL live in a shared package (chs_pkg) reused by the mode/power and fan stages.
REQ-030 The ramp generator (tick counter plus step toward target) SHALL be a sub-module named speed_ramp; the FSM and target computation stay in the top.

Verification (RAMP_DIV=4, RAMP_STEP=8, GAIN_SH=4, defaults otherwise)
REQ-031 Assert arst for 2 cycles with temp_data=40 valid -> speed=0, chs_mode=00, chs_power=0, state IDLE throughout reset.
REQ-032 temp 32 valid -> COOL, mode 01, power 1 two edges later; target 80; speed rises 8 per tick and holds 80 after 10 ticks.
REQ-033 Then temp 28 -> stays COOL, target 16, speed falls to 16; then temp 26 -> DRAIN with mode 01 and power 1 until speed=0, then IDLE with mode 00 and power 0.
REQ-034 temp 10 -> HEAT target 128; temp 50 while in COOL -> target saturates to 255 (error 23<<4=368 clipped).
REQ-035 temp 40 valid while in DRAIN from HEAT -> remains DRAIN until speed=0, then IDLE, then COOL using the latched value 40.
REQ-036 arst pulse with speed=48 in COOL -> next edge speed=0, mode 00, power 0; recovery follows REQ-032 timing.
